// File: rtl/branch_ctrl.sv
// Branch sequencing controller: predicts decode branches from a table of
// 2-bit saturating counters, tracks one accepted branch into execute and
// issues redirect/flush when the resolved outcome disagrees with the guess.
//
// state | meaning
// IDLE  | no branch in execute
// PEND  | latched branch is in execute this cycle and resolves now
module branch_ctrl #(
    parameter int BHT_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_br_valid,
    input  logic        id_br_uncond,
    input  logic [15:0] id_pc,
    input  logic [15:0] id_target,
    input  logic        id_stall,
    input  logic        ex_brchCnd,
    output logic        pred_taken,
    output logic        pred_redirect,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic [15:0] br_cnt,
    output logic [15:0] mispred_cnt
);

    localparam int BHT_SIZE = 1 << BHT_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [1:0]          bht [BHT_SIZE];
    logic [15:0]         pcPlus2Lat;
    logic [15:0]         targetLat;
    logic                predLat;
    logic                uncondLat;
    logic [BHT_BITS-1:0] idxLat;

    logic [BHT_BITS-1:0] idIdx;
    logic                bhtMsb;
    logic                actual;
    logic                mispred;
    logic                accept;

    assign idIdx  = id_pc[BHT_BITS:1];
    assign bhtMsb = bht[idIdx][1];

    // Prediction, resolution, and acceptance; reset suppresses an in-flight redirect.
    always_comb begin
        pred_taken    = id_br_valid & (id_br_uncond | bhtMsb);
        actual        = uncondLat | ex_brchCnd;
        mispred       = (state == PEND) & (actual != predLat) & ~rst;
        redirect      = mispred;
        flush         = mispred;
        redirect_pc   = 16'h0000;
        if (mispred) begin
            redirect_pc = actual ? targetLat : pcPlus2Lat;
        end
        accept        = id_br_valid & ~id_stall & ~flush;
        pred_redirect = pred_taken & ~id_stall & ~flush;
    end

    // Next-state: a correct resolution can hand PEND straight to a new branch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = accept ? PEND : IDLE;
            PEND: begin
                if (mispred) begin
                    nextState = IDLE;
                end else if (accept) begin
                    nextState = PEND;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, branch latch, predictor table and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pcPlus2Lat  <= 16'h0000;
            targetLat   <= 16'h0000;
            predLat     <= 1'b0;
            uncondLat   <= 1'b0;
            idxLat      <= '0;
            br_cnt      <= 16'h0000;
            mispred_cnt <= 16'h0000;
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            state <= nextState;
            if (accept) begin
                pcPlus2Lat <= id_pc + 16'd2;
                targetLat  <= id_target;
                predLat    <= pred_taken;
                uncondLat  <= id_br_uncond;
                idxLat     <= idIdx;
                if (br_cnt != 16'hFFFF) begin
                    br_cnt <= br_cnt + 16'd1;
                end
            end
            if (mispred && (mispred_cnt != 16'hFFFF)) begin
                mispred_cnt <= mispred_cnt + 16'd1;
            end
            if ((state == PEND) && !uncondLat) begin
                if (ex_brchCnd) begin
                    if (bht[idxLat] != 2'b11) begin
                        bht[idxLat] <= bht[idxLat] + 2'b01;
                    end
                end else begin
                    if (bht[idxLat] != 2'b00) begin
                        bht[idxLat] <= bht[idxLat] - 2'b01;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Vector bench for branch_ctrl: each table row is one clock cycle of decode
// and execute inputs together with the outputs expected in that cycle.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_br_valid = 1'b0;
    logic        id_br_uncond = 1'b0;
    logic [15:0] id_pc = 16'h0000;
    logic [15:0] id_target = 16'h0000;
    logic        id_stall = 1'b0;
    logic        ex_brchCnd = 1'b0;
    logic        pred_taken;
    logic        pred_redirect;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;
    logic [15:0] br_cnt;
    logic [15:0] mispred_cnt;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic        u;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        stall;
        logic        cnd;
        logic        pt;
        logic        pr;
        logic        rd;
        logic        fl;
        logic [15:0] rpc;
        logic        rpcCare;
        logic [15:0] br;
        logic [15:0] mp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    branch_ctrl #(.BHT_BITS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_br_valid  (id_br_valid),
        .id_br_uncond (id_br_uncond),
        .id_pc        (id_pc),
        .id_target    (id_target),
        .id_stall     (id_stall),
        .ex_brchCnd   (ex_brchCnd),
        .pred_taken   (pred_taken),
        .pred_redirect(pred_redirect),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .br_cnt       (br_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic v, logic u, logic [15:0] pc, logic [15:0] tgt,
                                logic st, logic cnd, logic pt, logic pr, logic rd, logic fl,
                                logic [15:0] rpc, logic care, logic [15:0] br, logic [15:0] mp);
        vec_t x;
        x.rst = r; x.v = v; x.u = u; x.pc = pc; x.tgt = tgt; x.stall = st; x.cnd = cnd;
        x.pt = pt; x.pr = pr; x.rd = rd; x.fl = fl; x.rpc = rpc; x.rpcCare = care;
        x.br = br; x.mp = mp;
        return x;
    endfunction

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s vec %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle on the falling edge, queue its expectation, compare 1 ns later.
    task automatic apply(vec_t x, int idx);
        vec_t e;
        @(negedge clk);
        rst          = x.rst;
        id_br_valid  = x.v;
        id_br_uncond = x.u;
        id_pc        = x.pc;
        id_target    = x.tgt;
        id_stall     = x.stall;
        ex_brchCnd   = x.cnd;
        sb.push_back(x);
        #1;
        e = sb.pop_front();
        chk("pred_taken",    idx, {15'd0, pred_taken},    {15'd0, e.pt});
        chk("pred_redirect", idx, {15'd0, pred_redirect}, {15'd0, e.pr});
        chk("redirect",      idx, {15'd0, redirect},      {15'd0, e.rd});
        chk("flush",         idx, {15'd0, flush},         {15'd0, e.fl});
        if (e.rpcCare) chk("redirect_pc", idx, redirect_pc, e.rpc);
        chk("br_cnt",        idx, br_cnt,      e.br);
        chk("mispred_cnt",   idx, mispred_cnt, e.mp);
    endtask

    initial begin
        //            rst v u pc        tgt       st cnd pt pr rd fl rpc       care br     mp
        // reset defaults, then BEQZ at 0x0010 learning taken
        tbl.push_back(mk(1,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,1, 16'd0, 16'd0));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 0,0,0,0,16'h0000,1, 16'd0, 16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0040,1, 16'd1, 16'd0));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 1,1,0,0,16'h0000,1, 16'd1, 16'd1));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,0,0,16'h0000,0, 16'd2, 16'd1));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 1,1,0,0,16'h0000,1, 16'd2, 16'd1));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,0,0,16'h0000,0, 16'd3, 16'd1));
        // entry at 3, not-taken: redirect to PC+2, counter 2 still predicts taken
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 1,1,0,0,16'h0000,1, 16'd3, 16'd1));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,1,1,16'h0012,1, 16'd4, 16'd1));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 1,1,0,0,16'h0000,1, 16'd4, 16'd2));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,1,1,16'h0012,1, 16'd5, 16'd2));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 0,0,0,0,16'h0000,1, 16'd5, 16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,0, 16'd6, 16'd3));
        // entry now 0: JUMP predicts taken, never redirects, table untouched
        tbl.push_back(mk(0,1,1,16'h0010,16'h0100,0,0, 1,1,0,0,16'h0000,1, 16'd6, 16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,0, 16'd7, 16'd3));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 0,0,0,0,16'h0000,1, 16'd7, 16'd3));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0040,1, 16'd8, 16'd3));
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 0,0,0,0,16'h0000,1, 16'd8, 16'd4));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0040,1, 16'd9, 16'd4));
        // A mispredicts while JUMP B sits in decode: B dropped
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 1,1,0,0,16'h0000,1, 16'd9, 16'd5));
        tbl.push_back(mk(0,1,1,16'h0034,16'h0080,0,0, 1,0,1,1,16'h0012,1, 16'd10,16'd5));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,0,0,16'h0000,1, 16'd10,16'd6));
        // A correct, B accepted back-to-back and resolves the next cycle
        tbl.push_back(mk(0,1,0,16'h0010,16'h0040,0,0, 0,0,0,0,16'h0000,1, 16'd10,16'd6));
        tbl.push_back(mk(0,1,0,16'h0032,16'h0090,0,0, 0,0,0,0,16'h0000,0, 16'd11,16'd6));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0090,1, 16'd12,16'd6));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,1, 16'd12,16'd7));
        // stall blocks acceptance
        tbl.push_back(mk(0,1,1,16'h0050,16'h0200,1,0, 1,0,0,0,16'h0000,1, 16'd12,16'd7));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,0,0,16'h0000,1, 16'd12,16'd7));
        // PC 0xFFFE: train taken, then not-taken wraps PC+2 to 0
        tbl.push_back(mk(0,1,0,16'hFFFE,16'h0100,0,0, 0,0,0,0,16'h0000,1, 16'd12,16'd7));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0100,1, 16'd13,16'd7));
        tbl.push_back(mk(0,1,0,16'hFFFE,16'h0100,0,0, 1,1,0,0,16'h0000,1, 16'd13,16'd8));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,1,1,16'h0000,1, 16'd14,16'd8));
        // reset during PEND: no redirect, table and counters cleared
        tbl.push_back(mk(0,1,0,16'h0032,16'h0090,0,0, 1,1,0,0,16'h0000,1, 16'd14,16'd9));
        tbl.push_back(mk(1,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,1, 16'd15,16'd9));
        tbl.push_back(mk(0,1,0,16'h0032,16'h0090,0,0, 0,0,0,0,16'h0000,1, 16'd0, 16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,1,1,16'h0090,1, 16'd1, 16'd0));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,1, 16'd1, 16'd1));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) apply(tbl[i], i);

        // held stall: branch re-presented for several cycles, accepted exactly once
        for (int k = 0; k < 4; k++) begin
            apply(mk(0,1,0,16'h0032,16'h0090,1,0, 1,0,0,0,16'h0000,1, 16'd1,16'd1), 100 + k);
        end
        apply(mk(0,1,0,16'h0032,16'h0090,0,0, 1,1,0,0,16'h0000,1, 16'd1,16'd1), 104);
        apply(mk(0,0,0,16'h0000,16'h0000,0,1, 0,0,0,0,16'h0000,0, 16'd2,16'd1), 105);
        apply(mk(0,0,0,16'h0000,16'h0000,0,0, 0,0,0,0,16'h0000,1, 16'd2,16'd1), 106);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
